div_unit: RTL
=============

# div_unit

Iterative RV32M divide unit (DIV, DIVU, REM, REMU) in the execute stage. It takes operands read from the register file's RD1/RD2 ports and drives that file's write port (WE3/A3/WD3) with the result. It uses one radix-2 restoring step per cycle and a start/busy handshake. Divide-by-zero and signed overflow complete early.

## Interface
- width, 32, operand/result width (even, ≥ 4)
- registers, 32, register count; address width is $clog2(registers)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy = 0
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_data  in  width  dividend (from RD1)
- rs2_data  in  width  divisor (from RD2)
- rd_addr  in  $clog2(registers)  destination register
- busy  out  1  request in flight; start ignored while high
- wb_we  out  1  one-cycle write strobe (to WE3)
- wb_addr  out  $clog2(registers)  destination (to A3)
- wb_data  out  width  result (to WD3)

## Operation
- States:
  - IDLE: busy = 0.
  - CALC: busy = 1, counter counts width down to 1.
  - DONE: busy = 1, wb_we = 1 if wb_addr ≠ 0.
- IDLE with start = 1:
  - Latch op and rd_addr.
  - Signed ops (DIV, REM) use the magnitudes of the operands. Record sign_q = sign(rs1) XOR sign(rs2) and sign_r = sign(rs1).
  - Divisor = 0: go to DONE. Result is all-ones for DIV/DIVU and rs1_data for REM/REMU.
  - Signed op with rs1 = 2^(width-1) and rs2 = all-ones: go to DONE. Result is rs1_data for DIV and 0 for REM.
  - Otherwise: go to CALC. Load quotient register = |dividend|, remainder = 0, counter = width.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem − divisor, computed in width+1 bits.
  - If trial is non-negative: rem = trial, quo LSB = 1. Otherwise quo LSB = 0.
  - Decrement the counter. When it reaches 0, go to DONE and latch wb_data:
    - quo or rem, selected by op[1];
    - DIV: negate the quotient if sign_q = 1;
    - REM: negate the remainder if sign_r = 1.
- DONE: go to IDLE on the next edge. wb_we deasserts.
- rd_addr = 0: full timing runs, but wb_we stays 0. x0 is never written.
- wb_addr and wb_data hold their values until the next result is latched.
- start while busy: ignored; no queuing.
- Reset at any time:
  - State = IDLE; busy, wb_we, wb_addr, wb_data = 0.
  - An in-flight operation is discarded; no writeback follows.

## Timing
- Accept edge E0 (start = 1, busy = 0). busy is high from E0 until the edge that returns to IDLE.
- Normal path:
  - CALC steps occur on E1..E_width.
  - wb_we is high in the cycle after E_width and falls at E_width+1.
  - busy falls at E_width+1.
  - Latency from start to write strobe: width+1 cycles (33 at default).
- Early path (divide-by-zero or overflow):
  - DONE is entered at E0, so wb_we is high in the cycle after E0.
  - busy falls at E1.
- The register file samples WE3/A3/WD3 on the edge ending the DONE cycle. The result is then readable combinationally the next cycle.
- Back-to-back: start may be accepted in the cycle after busy falls. It cannot be accepted in the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package rv_pkg holds:
  - op encoding localparams: OP_DIV, OP_DIVU, OP_REM, OP_REMU;
  - state encoding: S_IDLE, S_CALC, S_DONE.
- Sub-module divu_core:
  - unsigned restoring iteration, comprising the quo/rem/counter datapath and the step logic;
  - interface: load, operands, step-done flag.
- The top level owns:
  - the FSM;
  - sign pre- and post-processing;
  - the special-case detection;
  - the writeback registers.

## Test plan
- DIVU, rs1 = 100, rs2 = 7, rd = 5:
  - wb_data = 14, wb_addr = 5.
  - wb_we is a single-cycle pulse in cycle 33 after accept.
  - busy falls one cycle later.
- DIV, then REM, with rs1 = 0xFFFFFFF9 (−7) and rs2 = 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
- Divide by zero, rs1 = 0x12345678, rs2 = 0:
  - DIVU → 0xFFFFFFFF and REMU → 0x12345678.
  - wb_we is high in the cycle after accept.
- Signed overflow, rs1 = 0x80000000, rs2 = 0xFFFFFFFF:
  - DIV → 0x80000000 and REM → 0, both on the early path.
  - DIVU with the same operands → 0 after 33 cycles.
- rd = 0, DIVU 50/5:
  - busy timing is identical to the normal path.
  - wb_we stays 0 throughout.
- start pulsed at cycle 5 of CALC: ignored; the original result is written unchanged.
- rst asserted at cycle 10 of CALC:
  - busy, wb_we, and wb_data go to 0 immediately.
  - No strobe follows.
  - A new request after reset completes correctly.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV32M divide unit.
//   - OP_*  : two-bit operation encoding presented on div_unit.op
//   - S_*   : divide-unit FSM state encoding
// ---------------------------------------------------------------------------
package rv_pkg;

    // op[0] = 1 selects unsigned, op[1] = 1 selects remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : rv_pkg

// File: rtl/divu_core.sv
// ---------------------------------------------------------------------------
// divu_core
// Unsigned radix-2 restoring divider datapath: one quotient bit per cycle.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : capture dividend/divisor and start WIDTH iterations
//   dividend    : unsigned dividend (loaded into the quotient register)
//   divisor     : unsigned divisor
//   last_step   : high during the cycle whose edge performs the final step
//   quo_nxt     : quotient after the step taken on the coming edge
//   rem_nxt     : remainder after the step taken on the coming edge
// The *_nxt outputs let the owner latch the finished result on the same
// edge as the last iteration instead of one cycle later.
// ---------------------------------------------------------------------------
module divu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last_step,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    // {rem, quo} shifted left: the remainder gains the quotient MSB. The
    // remainder is always below the divisor, so WIDTH+1 bits never overflow.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dsr_q};
    assign trial_ok  = ~trial[WIDTH];

    assign rem_nxt   = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_nxt   = {quo_q[WIDTH-2:0], trial_ok};
    assign last_step = (cnt_q == CW'(1));

    // NOTE: the datapath registers are reset too, so a discarded operation
    // leaves no stale iteration running (cnt_q = 0 means "not stepping").
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, so step logic order inside the block is free.
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            cnt_q <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule : divu_core

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative RV32M divide unit (DIV, DIVU, REM, REMU) with start/busy
// handshake and a registered register-file write port.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request, accepted only while busy = 0
//   op        : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data  : dividend (RD1)
//   rs2_data  : divisor (RD2)
//   rd_addr   : destination register
//   busy      : request in flight, start ignored
//   wb_we     : one-cycle write strobe (WE3), never asserted for x0
//   wb_addr   : destination (A3), held until the next result
//   wb_data   : result (WD3), held until the next result
// Divide-by-zero and signed overflow bypass the iteration and finish in one
// cycle; everything else takes WIDTH restoring steps.
// ---------------------------------------------------------------------------
module div_unit
    import rv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REGISTERS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   op,
    input  logic [WIDTH-1:0]             rs1_data,
    input  logic [WIDTH-1:0]             rs2_data,
    input  logic [$clog2(REGISTERS)-1:0] rd_addr,
    output logic                         busy,
    output logic                         wb_we,
    output logic [$clog2(REGISTERS)-1:0] wb_addr,
    output logic [WIDTH-1:0]             wb_data
);

    localparam int AW = $clog2(REGISTERS);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t          state;
    logic [1:0]      op_q;
    logic [AW-1:0]   rd_q;
    logic            sign_q_q;   // quotient must be negated
    logic            sign_r_q;   // remainder must be negated

    // Request decode (only meaningful while accepting)
    logic             is_signed;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_zero;
    logic             overflow;
    logic             accept;
    logic             core_load;
    logic [WIDTH-1:0] early_result;

    // Core interface
    logic             last_step;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] final_result;

    assign is_signed = ~op[0];
    assign neg_a     = is_signed & rs1_data[WIDTH-1];
    assign neg_b     = is_signed & rs2_data[WIDTH-1];
    assign abs_a     = neg_a ? -rs1_data : rs1_data;
    assign abs_b     = neg_b ? -rs2_data : rs2_data;
    assign div_zero  = (rs2_data == '0);
    assign overflow  = is_signed && (rs1_data == INT_MIN) && (rs2_data == '1);
    assign accept    = (state == S_IDLE) && start;
    assign core_load = accept && !div_zero && !overflow;

    // Divide-by-zero takes priority; overflow can only occur with a
    // non-zero divisor anyway.
    always_comb begin
        early_result = '0;
        if (div_zero)
            early_result = op[1] ? rs1_data : '1;
        else
            early_result = op[1] ? '0 : rs1_data;
    end

    // Post-processing uses the quo/rem values produced by the final step so
    // the result lands on the same edge as that step.
    always_comb begin
        final_result = '0;
        case (op_q)
            OP_DIV:  final_result = sign_q_q ? -quo_nxt : quo_nxt;
            OP_DIVU: final_result = quo_nxt;
            OP_REM:  final_result = sign_r_q ? -rem_nxt : rem_nxt;
            OP_REMU: final_result = rem_nxt;
            default: final_result = '0;
        endcase
    end

    divu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .last_step (last_step),
        .quo_nxt   (quo_nxt),
        .rem_nxt   (rem_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_DIV;
            rd_q     <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            busy     <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        rd_q     <= rd_addr;
                        sign_q_q <= neg_a ^ neg_b;
                        sign_r_q <= neg_a;
                        busy     <= 1'b1;
                        if (div_zero || overflow) begin
                            wb_data <= early_result;
                            wb_addr <= rd_addr;
                            wb_we   <= (rd_addr != '0);
                            state   <= S_DONE;
                        end else begin
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (last_step) begin
                        wb_data <= final_result;
                        wb_addr <= rd_q;
                        wb_we   <= (rd_q != '0);
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    wb_we <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    wb_we <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : div_unit
